// File: rtl/analyst_frame_ctrl.sv
// Per-frame sequencer for the extremum/centre/angle analysis datapath: clears it,
// scans the active window, waits for it to settle, then offers a result snapshot.
module analyst_frame_ctrl #(
    parameter int H_ACT      = 640,
    parameter int V_ACT      = 480,
    parameter int CLR_CYC    = 3,
    parameter int SETTLE_CYC = 3,
    parameter int DECIM      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic        pix_bin,
    output logic        an_en,
    output logic        an_bin,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic        new_frm,
    input  logic [11:0] dp_centre_x,
    input  logic [11:0] dp_centre_y,
    input  logic [9:0]  dp_angle_x,
    input  logic [9:0]  dp_angle_y,
    input  logic        dp_dir,
    output logic [11:0] res_centre_x,
    output logic [11:0] res_centre_y,
    output logic [9:0]  res_angle_x,
    output logic [9:0]  res_angle_y,
    output logic        res_dir,
    output logic        res_obj,
    output logic [7:0]  res_frame_id,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  drop_cnt,
    output logic        ovr_err
);

    typedef enum logic [2:0] {IDLE, CLEAR, SCAN, SETTLE, OFFER} state_t;

    localparam logic [9:0] X_LAST      = 10'(H_ACT - 1);
    localparam logic [9:0] Y_LAST      = 10'(V_ACT - 1);
    localparam logic [7:0] CLR_LAST    = 8'(CLR_CYC - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] DECIM_LAST  = 8'(DECIM - 1);

    state_t     state, state_nxt;
    logic [7:0] frame_id;
    logic [7:0] cur_id;
    logic [7:0] decim_cnt;
    logic [7:0] cyc_cnt;
    logic       obj;
    logic       selected;
    logic       last_pix;
    logic       start_frm;
    logic       capture;

    assign selected  = (decim_cnt == 8'd0);
    assign last_pix  = pix_valid && (pos_x == X_LAST) && (pos_y == Y_LAST);
    assign start_frm = frame_start && selected && ((state == IDLE) || (state == SCAN));
    assign capture   = (state == SETTLE) && (state_nxt == OFFER);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (frame_start && selected) state_nxt = CLEAR;
            CLEAR:  if (cyc_cnt == CLR_LAST) state_nxt = SCAN;
            SCAN: begin
                // a new vsync mid-scan abandons the current frame
                if (frame_start)   state_nxt = selected ? CLEAR : IDLE;
                else if (last_pix) state_nxt = SETTLE;
            end
            SETTLE: if (cyc_cnt == SETTLE_LAST) state_nxt = OFFER;
            OFFER:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign new_frm   = (state == CLEAR);
    assign an_en     = (state == SCAN) && pix_valid;
    assign an_bin    = (state == SCAN) && pix_bin;
    assign res_valid = (state == OFFER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            frame_id     <= '0;
            cur_id       <= '0;
            decim_cnt    <= '0;
            cyc_cnt      <= '0;
            obj          <= 1'b0;
            pos_x        <= '0;
            pos_y        <= '0;
            drop_cnt     <= '0;
            ovr_err      <= 1'b0;
            res_centre_x <= '0;
            res_centre_y <= '0;
            res_angle_x  <= '0;
            res_angle_y  <= '0;
            res_dir      <= 1'b0;
            res_obj      <= 1'b0;
            res_frame_id <= '0;
        end else begin
            state <= state_nxt;

            if (frame_start) begin
                frame_id  <= frame_id + 8'd1;
                decim_cnt <= (decim_cnt == DECIM_LAST) ? 8'd0 : decim_cnt + 8'd1;
            end

            if (state_nxt != state)
                cyc_cnt <= '0;
            else if ((state == CLEAR) || (state == SETTLE))
                cyc_cnt <= cyc_cnt + 8'd1;

            // coordinates and object flag restart with every analysed frame
            if (start_frm) begin
                pos_x  <= '0;
                pos_y  <= '0;
                obj    <= 1'b0;
                cur_id <= frame_id + 8'd1;
            end else if (state == IDLE) begin
                pos_x <= '0;
                pos_y <= '0;
                obj   <= 1'b0;
            end else if ((state == SCAN) && pix_valid && !frame_start) begin
                if (!pix_bin) obj <= 1'b1;
                if (pos_x == X_LAST) begin
                    pos_x <= '0;
                    pos_y <= (pos_y == Y_LAST) ? 10'd0 : pos_y + 10'd1;
                end else begin
                    pos_x <= pos_x + 10'd1;
                end
            end

            if ((pix_valid && ((state == CLEAR) || (state == SETTLE))) ||
                ((state == SCAN) && frame_start))
                ovr_err <= 1'b1;

            if ((state == OFFER) && frame_start && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;

            if (capture) begin
                res_centre_x <= dp_centre_x;
                res_centre_y <= dp_centre_y;
                res_angle_x  <= dp_angle_x;
                res_angle_y  <= dp_angle_y;
                res_dir      <= dp_dir;
                res_obj      <= obj;
                res_frame_id <= cur_id;
            end
        end
    end

endmodule

// File: tb/tb_analyst_frame_ctrl.sv
// Directed bench for analyst_frame_ctrl on a 4x2 window; a second instance with
// DECIM = 3 shares the stimulus and is examined only for frame decimation.
module tb_analyst_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_bin = 1'b1;
    logic        res_ready = 1'b0;
    logic [11:0] dp_centre_x = '0;
    logic [11:0] dp_centre_y = '0;
    logic [9:0]  dp_angle_x = '0;
    logic [9:0]  dp_angle_y = '0;
    logic        dp_dir = 1'b0;

    logic        an_en, an_bin, new_frm, res_dir, res_obj, res_valid, ovr_err;
    logic [9:0]  pos_x, pos_y, res_angle_x, res_angle_y;
    logic [11:0] res_centre_x, res_centre_y;
    logic [7:0]  res_frame_id, drop_cnt;

    logic        an_en_d, an_bin_d, new_frm_d, res_dir_d, res_obj_d, res_valid_d, ovr_err_d;
    logic [9:0]  pos_x_d, pos_y_d, res_angle_x_d, res_angle_y_d;
    logic [11:0] res_centre_x_d, res_centre_y_d;
    logic [7:0]  res_frame_id_d, drop_cnt_d;

    int checks = 0;
    int errors = 0;
    int en_cnt;
    int mon;
    int n_main, n_dec;
    logic [7:0] ids_dec [0:7];

    always #5 clk = ~clk;

    analyst_frame_ctrl #(.H_ACT(4), .V_ACT(2), .CLR_CYC(3), .SETTLE_CYC(3), .DECIM(1)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid), .pix_bin(pix_bin),
        .an_en(an_en), .an_bin(an_bin), .pos_x(pos_x), .pos_y(pos_y), .new_frm(new_frm),
        .dp_centre_x(dp_centre_x), .dp_centre_y(dp_centre_y), .dp_angle_x(dp_angle_x),
        .dp_angle_y(dp_angle_y), .dp_dir(dp_dir),
        .res_centre_x(res_centre_x), .res_centre_y(res_centre_y), .res_angle_x(res_angle_x),
        .res_angle_y(res_angle_y), .res_dir(res_dir), .res_obj(res_obj),
        .res_frame_id(res_frame_id), .res_valid(res_valid), .res_ready(res_ready),
        .drop_cnt(drop_cnt), .ovr_err(ovr_err)
    );

    analyst_frame_ctrl #(.H_ACT(4), .V_ACT(2), .CLR_CYC(3), .SETTLE_CYC(3), .DECIM(3)) dut_d (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid), .pix_bin(pix_bin),
        .an_en(an_en_d), .an_bin(an_bin_d), .pos_x(pos_x_d), .pos_y(pos_y_d), .new_frm(new_frm_d),
        .dp_centre_x(dp_centre_x), .dp_centre_y(dp_centre_y), .dp_angle_x(dp_angle_x),
        .dp_angle_y(dp_angle_y), .dp_dir(dp_dir),
        .res_centre_x(res_centre_x_d), .res_centre_y(res_centre_y_d), .res_angle_x(res_angle_x_d),
        .res_angle_y(res_angle_y_d), .res_dir(res_dir_d), .res_obj(res_obj_d),
        .res_frame_id(res_frame_id_d), .res_valid(res_valid_d), .res_ready(res_ready),
        .drop_cnt(drop_cnt_d), .ovr_err(ovr_err_d)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Records handshakes that the coming edge will complete, then moves 1 ns past it.
    task automatic tick();
        if (mon != 0) begin
            if (res_valid && res_ready) n_main++;
            if (res_valid_d && res_ready) begin
                if (n_dec < 8) ids_dec[n_dec] = res_frame_id_d;
                n_dec++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic run_pixels(input int n, input int zero_idx);
        en_cnt = 0;
        for (int p = 0; p < n; p++) begin
            pix_valid = 1'b1;
            pix_bin   = (p == zero_idx) ? 1'b0 : 1'b1;
            #1;
            en_cnt += int'(an_en);
            if (p == zero_idx) chk("an_bin_zero", 32'(an_bin), 32'd0);
            tick();
        end
        pix_valid = 1'b0;
        pix_bin   = 1'b1;
    endtask

    task automatic full_frame(input int zero_idx);
        pulse_start();
        repeat (4) tick();
        run_pixels(8, zero_idx);
    endtask

    task automatic wait_offer(output int cyc);
        cyc = 0;
        while (!res_valid && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int nf_cnt;
        mon = 0;
        n_main = 0;
        n_dec = 0;
        do_reset();

        // reset state
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_pos_x", 32'(pos_x), 32'd0);
        chk("rst_new_frm", 32'(new_frm), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_ovr_err", 32'(ovr_err), 32'd0);

        // nominal frame, object pixel only at (2,1)
        dp_centre_x = 12'hABC; dp_centre_y = 12'h123;
        dp_angle_x = 10'h2A5; dp_angle_y = 10'h15A; dp_dir = 1'b1;
        pulse_start();
        nf_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            nf_cnt += int'(new_frm);
            if (i < 4) tick();
        end
        chk("new_frm_cycles", 32'(nf_cnt), 32'd3);
        run_pixels(8, 6);
        chk("an_en_cycles", 32'(en_cnt), 32'd8);
        wait_offer(cyc);
        chk("offer_latency", 32'(cyc), 32'd3);
        chk("nom_res_obj", 32'(res_obj), 32'd1);
        chk("nom_centre_x", 32'(res_centre_x), 32'hABC);
        chk("nom_centre_y", 32'(res_centre_y), 32'h123);
        chk("nom_angle_x", 32'(res_angle_x), 32'h2A5);
        chk("nom_angle_y", 32'(res_angle_y), 32'h15A);
        chk("nom_dir", 32'(res_dir), 32'd1);
        chk("nom_frame_id", 32'(res_frame_id), 32'd1);
        chk("nom_ovr_err", 32'(ovr_err), 32'd0);

        // backpressure: three vsyncs while the offer is pending
        dp_centre_x = 12'h555;
        pix_valid = 1'b1;
        #1;
        chk("offer_an_en", 32'(an_en), 32'd0);
        pix_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse_start();
            tick();
        end
        chk("bp_res_valid", 32'(res_valid), 32'd1);
        chk("bp_centre_x", 32'(res_centre_x), 32'hABC);
        chk("bp_frame_id", 32'(res_frame_id), 32'd1);
        chk("bp_drop_cnt", 32'(drop_cnt), 32'd3);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("bp_release", 32'(res_valid), 32'd0);

        // asynchronous reset in the middle of a scan
        pulse_start();
        repeat (4) tick();
        run_pixels(3, -1);
        chk("pre_rst_pos_x", 32'(pos_x), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pos_x", 32'(pos_x), 32'd0);
        chk("arst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("arst_res_frame_id", 32'(res_frame_id), 32'd0);
        chk("arst_centre_x", 32'(res_centre_x), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        pix_valid = 1'b1;
        #1;
        chk("arst_idle_an_en", 32'(an_en), 32'd0);
        chk("arst_idle_new_frm", 32'(new_frm), 32'd0);
        pix_valid = 1'b0;

        // truncated frame followed by a complete one
        do_reset();
        pulse_start();
        repeat (4) tick();
        run_pixels(5, -1);
        chk("trunc_pre_ovr", 32'(ovr_err), 32'd0);
        pulse_start();
        chk("trunc_ovr_err", 32'(ovr_err), 32'd1);
        chk("trunc_new_frm", 32'(new_frm), 32'd1);
        chk("trunc_no_valid", 32'(res_valid), 32'd0);
        repeat (4) tick();
        run_pixels(8, -1);
        wait_offer(cyc);
        chk("trunc_latency", 32'(cyc), 32'd3);
        chk("trunc_frame_id", 32'(res_frame_id), 32'd2);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // decimation: six full frames, DECIM = 3 instance offers frames 1 and 4
        do_reset();
        res_ready = 1'b1;
        mon = 1;
        for (int f = 0; f < 6; f++) begin
            full_frame(0);
            repeat (6) tick();
        end
        mon = 0;
        res_ready = 1'b0;
        chk("dec_main_offers", 32'(n_main), 32'd6);
        chk("dec_offers", 32'(n_dec), 32'd2);
        chk("dec_id_first", 32'(ids_dec[0]), 32'd1);
        chk("dec_id_second", 32'(ids_dec[1]), 32'd4);

        // empty frame, then a pixel while clearing
        do_reset();
        full_frame(-1);
        wait_offer(cyc);
        chk("empty_valid", 32'(res_valid), 32'd1);
        chk("empty_res_obj", 32'(res_obj), 32'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("empty_pre_ovr", 32'(ovr_err), 32'd0);
        pulse_start();
        pix_valid = 1'b1;
        #1;
        chk("clear_an_en", 32'(an_en), 32'd0);
        tick();
        pix_valid = 1'b0;
        chk("clear_ovr_err", 32'(ovr_err), 32'd1);
        chk("clear_pos_x", 32'(pos_x), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
